// File: rtl/add_share_pkg.sv
// Shared types and constants for the chunked add/subtract sequencer.
package add_share_pkg;

    localparam int CHUNK_W = 7;
    localparam int NCHUNK  = 2;
    localparam int OP_W    = CHUNK_W * NCHUNK;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    // Carry out of a bit position rebuilt from its operands and sum bit:
    // when a^b is set the sum bit is the inverted carry-in, which is also the carry-out.
    function automatic logic chunk_carry(input logic a, input logic b, input logic s);
        return (a & b) | ((a ^ b) & ~s);
    endfunction

endpackage

// File: rtl/alt_carry_look_ahead_adder_cin7.sv
// 7-bit carry-look-ahead adder with carry-in and no carry-out port.
module alt_carry_look_ahead_adder_cin7
    import add_share_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum
);

    logic [CHUNK_W-1:0] g;
    logic [CHUNK_W-1:0] p;
    logic [CHUNK_W-1:0] c;
    logic               cy;
    logic               prop;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flattened OR of generate terms gated by the propagate run above them.
    always_comb begin
        c    = '0;
        cy   = 1'b0;
        prop = 1'b1;
        c[0] = cin;
        for (int i = 1; i < CHUNK_W; i++) begin
            cy   = 1'b0;
            prop = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                cy   = cy | (g[j] & prop);
                prop = prop & p[j];
            end
            c[i] = cy | (prop & cin);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/add_share_sequencer.sv
// Round-robin arbiter that runs 14-bit add/sub ops through one 7-bit adder in two passes.
module add_share_sequencer #(
    parameter int CHUNK_W = 7,
    parameter int NCHUNK  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [CHUNK_W*NCHUNK-1:0]   req0_a,
    input  logic [CHUNK_W*NCHUNK-1:0]   req0_b,
    input  logic                        req0_cin,
    input  logic                        req0_sub,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [CHUNK_W*NCHUNK-1:0]   req1_a,
    input  logic [CHUNK_W*NCHUNK-1:0]   req1_b,
    input  logic                        req1_cin,
    input  logic                        req1_sub,
    output logic                        rsp0_valid,
    input  logic                        rsp0_ready,
    output logic [CHUNK_W*NCHUNK-1:0]   rsp0_sum,
    output logic                        rsp0_cout,
    output logic                        rsp0_ovf,
    output logic                        rsp1_valid,
    input  logic                        rsp1_ready,
    output logic [CHUNK_W*NCHUNK-1:0]   rsp1_sum,
    output logic                        rsp1_cout,
    output logic                        rsp1_ovf
);
    import add_share_pkg::*;

    localparam int W = CHUNK_W * NCHUNK;

    state_t             state;
    logic               owner;
    logic               last_grant;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic               c0;
    logic               k;
    logic [W-1:0]       res;
    logic               cout_r;
    logic               ovf_r;
    logic [1:0]         rsp_vld;

    logic               any_req;
    logic               win;
    logic               idle;
    logic [W-1:0]       sel_a;
    logic [W-1:0]       sel_b;
    logic               sel_cin;
    logic               sel_sub;
    logic               rsp_take;

    logic [CHUNK_W-1:0] add_a;
    logic [CHUNK_W-1:0] add_b;
    logic               add_cin;
    logic [CHUNK_W-1:0] add_s;

    // On contention the requester that did not go last wins.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) win = ~last_grant;
        else if (req1_valid)          win = 1'b1;
    end

    assign any_req    = req0_valid | req1_valid;
    assign idle       = rst_n && (state == IDLE);
    assign req0_ready = idle & any_req & ~win;
    assign req1_ready = idle & any_req & win;

    assign sel_a    = win ? req1_a   : req0_a;
    assign sel_b    = win ? req1_b   : req0_b;
    assign sel_cin  = win ? req1_cin : req0_cin;
    assign sel_sub  = win ? req1_sub : req0_sub;
    assign rsp_take = owner ? rsp1_ready : rsp0_ready;

    assign add_a   = (state == HI) ? op_a[W-1:CHUNK_W] : op_a[CHUNK_W-1:0];
    assign add_b   = (state == HI) ? op_b[W-1:CHUNK_W] : op_b[CHUNK_W-1:0];
    assign add_cin = (state == HI) ? k : c0;

    alt_carry_look_ahead_adder_cin7 u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            c0         <= 1'b0;
            k          <= 1'b0;
            res        <= '0;
            cout_r     <= 1'b0;
            ovf_r      <= 1'b0;
            rsp_vld    <= 2'b00;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner <= win;
                    op_a  <= sel_a;
                    op_b  <= sel_sub ? ~sel_b : sel_b;
                    c0    <= sel_sub | sel_cin;
                    state <= LO;
                end
                LO: begin
                    res[CHUNK_W-1:0] <= add_s;
                    k     <= chunk_carry(op_a[CHUNK_W-1], op_b[CHUNK_W-1], add_s[CHUNK_W-1]);
                    state <= HI;
                end
                HI: begin
                    res[W-1:CHUNK_W] <= add_s;
                    cout_r  <= chunk_carry(op_a[W-1], op_b[W-1], add_s[CHUNK_W-1]);
                    ovf_r   <= (op_a[W-1] == op_b[W-1]) && (add_s[CHUNK_W-1] != op_a[W-1]);
                    rsp_vld <= owner ? 2'b10 : 2'b01;
                    state   <= RESP;
                end
                RESP: if (rsp_take) begin
                    rsp_vld    <= 2'b00;
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = rsp_vld[0];
    assign rsp1_valid = rsp_vld[1];
    assign rsp0_sum   = res;
    assign rsp1_sum   = res;
    assign rsp0_cout  = cout_r;
    assign rsp1_cout  = cout_r;
    assign rsp0_ovf   = ovf_r;
    assign rsp1_ovf   = ovf_r;

endmodule

// File: tb/tb_add_share_sequencer.sv
// Bench for add_share_sequencer: vector table, scoreboard of accepted ops, arbitration/reset sequences.
module tb_add_share_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req0_cin, req0_sub;
    logic [13:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin, req1_sub;
    logic [13:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_cout, rsp0_ovf;
    logic [13:0] rsp0_sum;
    logic        rsp1_valid, rsp1_ready, rsp1_cout, rsp1_ovf;
    logic [13:0] rsp1_sum;

    always #5 clk = ~clk;

    add_share_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_sub(req1_sub),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum),
        .rsp0_cout(rsp0_cout), .rsp0_ovf(rsp0_ovf),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum),
        .rsp1_cout(rsp1_cout), .rsp1_ovf(rsp1_ovf)
    );

    typedef struct { logic id; logic [13:0] sum; logic cout; logic ovf; } exp_t;
    typedef struct { logic id; logic [13:0] a; logic [13:0] b; logic cin; logic sub;
                     logic [13:0] sum; logic cout; logic ovf; } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb[$];
    logic grant_log[$];
    int   acc_log[$];
    exp_t last_rsp;
    logic got_rsp = 1'b0;
    logic [1:0] prev_vld = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: unsigned/signed integer arithmetic, independent of bit-level carry tricks.
    function automatic logic [15:0] model(input logic [13:0] a, input logic [13:0] b,
                                          input logic cin, input logic sub);
        int ua, ub, sa, sbv, u, r;
        logic [31:0] uu;
        logic co, ov;
        ua  = int'(a);
        ub  = int'(b);
        sa  = a[13] ? ua - 16384 : ua;
        sbv = b[13] ? ub - 16384 : ub;
        if (sub) begin
            u  = ua - ub;
            co = (ua >= ub);
            r  = sa - sbv;
        end else begin
            u  = ua + ub + int'(cin);
            co = (u > 16383);
            r  = sa + sbv + int'(cin);
        end
        ov = (r > 8191) || (r < -8192);
        uu = u;
        return {ov, co, uu[13:0]};
    endfunction

    task automatic push_exp(input logic id);
        logic [15:0] m;
        exp_t e;
        m = id ? model(req1_a, req1_b, req1_cin, req1_sub) : model(req0_a, req0_b, req0_cin, req0_sub);
        e.id = id; e.sum = m[13:0]; e.cout = m[14]; e.ovf = m[15];
        sb.push_back(e);
        grant_log.push_back(id);
        acc_log.push_back(cyc);
        acc_cyc = cyc;
    endtask

    // Accept monitor: an accepted op enqueues its expected result.
    always @(negedge clk) if (rst_n) begin
        if (req0_ready && req1_ready) check("both_ready", 1, 0);
        if (req0_valid && req0_ready) push_exp(1'b0);
        if (req1_valid && req1_ready) push_exp(1'b1);
    end

    // Response monitor: latency on rising valid, scoreboard compare on handshake.
    always @(negedge clk) if (rst_n) begin
        exp_t e;
        if (rsp0_valid && rsp1_valid) check("both_rsp_valid", 1, 0);
        if ((rsp0_valid && !prev_vld[0]) || (rsp1_valid && !prev_vld[1]))
            check("latency", cyc - acc_cyc, 3);
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            last_rsp.id   = rsp1_valid;
            last_rsp.sum  = rsp1_valid ? rsp1_sum  : rsp0_sum;
            last_rsp.cout = rsp1_valid ? rsp1_cout : rsp0_cout;
            last_rsp.ovf  = rsp1_valid ? rsp1_ovf  : rsp0_ovf;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_id",   last_rsp.id,   e.id);
                check("sb_sum",  last_rsp.sum,  e.sum);
                check("sb_cout", last_rsp.cout, e.cout);
                check("sb_ovf",  last_rsp.ovf,  e.ovf);
            end
            got_rsp = 1'b1;
        end
        prev_vld = {rsp1_valid, rsp0_valid};
    end

    task automatic drive(input logic id, input logic [13:0] a, input logic [13:0] b,
                         input logic cin, input logic sub);
        if (id) begin req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_valid = 1'b1; end
    endtask

    task automatic wait_ready(input logic id, input string name);
        int t = 0;
        do begin @(negedge clk); t++; end
        while (!(id ? req1_ready : req0_ready) && t < 50);
        if (!(id ? req1_ready : req0_ready)) check(name, 0, 1);
    endtask

    task automatic do_op(input logic id, input logic [13:0] a, input logic [13:0] b,
                         input logic cin, input logic sub);
        int t = 0;
        got_rsp = 1'b0;
        drive(id, a, b, cin, sub);
        wait_ready(id, "accept_timeout");
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        while (!got_rsp && t < 50) begin @(negedge clk); t++; end
        if (!got_rsp) check("rsp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
        check("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_ready"}, {req1_ready, req0_ready}, 0);
        check({name, "_valid"}, {rsp1_valid, rsp0_valid}, 0);
        check({name, "_sum"},   {rsp1_sum, rsp0_sum}, 0);
        check({name, "_flags"}, {rsp1_cout, rsp0_cout, rsp1_ovf, rsp0_ovf}, 0);
    endtask

    vec_t vt[8];

    initial begin
        logic [13:0] held;
        int t;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] held;
        int t;
        vt[0] = '{1'b0, 14'h007F, 14'h0001, 1'b0, 1'b0, 14'h0080, 1'b0, 1'b0};
        vt[1] = '{1'b1, 14'h3FFF, 14'h0001, 1'b0, 1'b0, 14'h0000, 1'b1, 1'b0};
        vt[2] = '{1'b1, 14'h1FFF, 14'h0001, 1'b0, 1'b0, 14'h2000, 1'b0, 1'b1};
        vt[3] = '{1'b0, 14'h0005, 14'h0007, 1'b0, 1'b1, 14'h3FFE, 1'b0, 1'b0};
        vt[4] = '{1'b0, 14'h2000, 14'h0001, 1'b0, 1'b1, 14'h1FFF, 1'b1, 1'b1};
        vt[5] = '{1'b1, 14'h0040, 14'h003F, 1'b1, 1'b0, 14'h0080, 1'b0, 1'b0};
        vt[6] = '{1'b0, 14'h0007, 14'h0005, 1'b1, 1'b1, 14'h0002, 1'b1, 1'b0};
        vt[7] = '{1'b1, 14'h2000, 14'h2000, 1'b0, 1'b0, 14'h0000, 1'b1, 1'b1};

        req0_a = '0; req0_b = '0; req0_cin = 0; req0_sub = 0;
        req1_a = '0; req1_b = '0; req1_cin = 0; req1_sub = 0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #2;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        req0_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-derived results.
        for (int i = 0; i < 8; i++) begin
            do_op(vt[i].id, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub);
            check($sformatf("vec%0d_sum", i),  last_rsp.sum,  vt[i].sum);
            check($sformatf("vec%0d_cout", i), last_rsp.cout, vt[i].cout);
            check($sformatf("vec%0d_ovf", i),  last_rsp.ovf,  vt[i].ovf);
        end

        for (int i = 0; i < 12; i++) begin
            logic id; logic [13:0] ra, rb; logic rc, rs;
            id = 1'($urandom_range(0, 1)); ra = 14'($urandom); rb = 14'($urandom);
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            do_op(id, ra, rb, rc, rs);
        end

        // Response backpressure while the other requester waits.
        rsp0_ready = 1'b0;
        drive(1'b0, 14'h0123, 14'h0456, 1'b0, 1'b0);
        wait_ready(1'b0, "bp_accept");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive(1'b1, 14'h0100, 14'h0200, 1'b0, 1'b1);
        t = 0;
        while (!rsp0_valid && t < 20) begin @(negedge clk); t++; end
        check("bp_valid_seen", rsp0_valid, 1);
        held = rsp0_sum;
        check("bp_sum", held, 14'h0579);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp0_valid, 1);
            check("bp_hold_sum", rsp0_sum, held);
            check("bp_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        wait_ready(1'b1, "bp_req1_accept");
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();

        // Both requesters valid from reset: grants alternate starting with req0.
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1'b0, 14'h0011, 14'h0022, 1'b0, 1'b0);
        drive(1'b1, 14'h0300, 14'h0100, 1'b0, 1'b1);
        grant_log.delete(); acc_log.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        t = 0;
        while (grant_log.size() < 6 && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        check("rr_count", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size(); i++) begin
            check($sformatf("rr_grant%0d", i), grant_log[i], i % 2);
            if (i > 0) check("rr_spacing", acc_log[i] - acc_log[i-1], 4);
        end

        // Lone requester is granted back-to-back every 4 cycles.
        grant_log.delete(); acc_log.delete();
        drive(1'b1, 14'h0AAA, 14'h1555, 1'b1, 1'b0);
        t = 0;
        while (grant_log.size() < 4 && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();
        check("solo_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size(); i++) begin
            check("solo_grant", grant_log[i], 1);
            if (i > 0) check("solo_spacing", acc_log[i] - acc_log[i-1], 4);
        end

        // Leave cout/ovf set, then reset during HI of the next op.
        do_op(1'b1, 14'h2000, 14'h2000, 1'b0, 1'b0);
        drive(1'b0, 14'h0FFF, 14'h0001, 1'b0, 1'b0);
        wait_ready(1'b0, "rst_accept");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_rst");
        sb.delete();
        drive(1'b0, 14'h0001, 14'h0002, 1'b0, 1'b0);
        drive(1'b1, 14'h0003, 14'h0004, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_zero_outputs("in_rst");
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("post_rst_req0_ready", req0_ready, 1);
        check("post_rst_req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        got_rsp = 1'b0;
        drain();
        check("post_rst_rsp", got_rsp, 1);
        check("post_rst_id", last_rsp.id, 0);
        check("post_rst_sum", last_rsp.sum, 14'h0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
